// File: rtl/acq_window_ctrl.sv
// Acquisition window controller: ring-down dead time after each u_blank pulse,
// then a record_len-sample capture window; counts scans up to n_scans.
// Optional ADC over-range flag built only when ACQ_OVR_EN is defined.
module acq_window_ctrl #(
  parameter int DW = 14,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          u_blank,
  input  logic [LW-1:0] dead_time,
  input  logic [LW-1:0] record_len,
  input  logic [LW-1:0] n_scans,
  input  logic [DW-1:0] adc_data,
  output logic          sample_valid,
  output logic [DW-1:0] sample_data,
  output logic [LW-1:0] sample_idx,
  output logic          scan_done,
  output logic          all_done,
  output logic          busy,
  output logic          ovr_flag
);

  typedef enum logic [1:0] {IDLE, DEAD, CAPT, DONE} state_t;

  localparam logic [LW-1:0] ONE = LW'(1);

  state_t        state;
  logic          u_blank_q;
  logic          fall;
  logic [LW-1:0] cnt;
  logic [LW-1:0] len_sh;
  logic [LW-1:0] nscan_sh;
  logic [LW-1:0] scan_cnt;

  assign fall = u_blank_q & ~u_blank;

`ifdef ACQ_OVR_EN
  logic ovr_hit;
  assign ovr_hit = (adc_data == '1) || (adc_data == '0);
`else
  assign ovr_flag = 1'b0;
`endif

  // cnt doubles as the dead-time down-counter and the in-scan sample index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      u_blank_q    <= 1'b0;
      cnt          <= '0;
      len_sh       <= '0;
      nscan_sh     <= '0;
      scan_cnt     <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_idx   <= '0;
      scan_done    <= 1'b0;
      all_done     <= 1'b0;
      busy         <= 1'b0;
`ifdef ACQ_OVR_EN
      ovr_flag     <= 1'b0;
`endif
    end else begin
      u_blank_q <= u_blank;
      scan_done <= 1'b0;
      if (!enable) begin
        state        <= IDLE;
        cnt          <= '0;
        scan_cnt     <= '0;
        sample_valid <= 1'b0;
        all_done     <= 1'b0;
        busy         <= 1'b0;
`ifdef ACQ_OVR_EN
        ovr_flag     <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              len_sh   <= record_len;
              nscan_sh <= n_scans;
              busy     <= 1'b1;
              if (dead_time == '0) begin
                state <= CAPT;
                cnt   <= '0;
              end else begin
                state <= DEAD;
                cnt   <= dead_time - ONE;
              end
            end
          end
          DEAD: begin
            if (cnt == '0) state <= CAPT;
            else           cnt   <= cnt - ONE;
          end
          CAPT: begin
            if (cnt != len_sh) begin
              sample_valid <= 1'b1;
              sample_data  <= adc_data;
              sample_idx   <= cnt;
              cnt          <= cnt + ONE;
`ifdef ACQ_OVR_EN
              if (ovr_hit) ovr_flag <= 1'b1;
`endif
            end else begin
              sample_valid <= 1'b0;
              busy         <= 1'b0;
              scan_done    <= 1'b1;
              scan_cnt     <= scan_cnt + ONE;
              cnt          <= '0;
              if (nscan_sh != '0 && (scan_cnt + ONE) == nscan_sh) begin
                state    <= DONE;
                all_done <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
          DONE: all_done <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_window_ctrl.sv
// Directed self-checking bench for acq_window_ctrl (latency, scan counting,
// retrigger immunity, enable abort, zero-length scans, over-range flag).
module tb_acq_window_ctrl;
  localparam int DW = 14;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          u_blank = 1'b0;
  logic [LW-1:0] dead_time = '0;
  logic [LW-1:0] record_len = '0;
  logic [LW-1:0] n_scans = '0;
  logic [DW-1:0] adc_data = '0;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic [LW-1:0] sample_idx;
  logic          scan_done;
  logic          all_done;
  logic          busy;
  logic          ovr_flag;

  int checks = 0;
  int passed = 0;

  acq_window_ctrl #(.DW(DW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .u_blank(u_blank),
    .dead_time(dead_time), .record_len(record_len), .n_scans(n_scans),
    .adc_data(adc_data), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_idx(sample_idx), .scan_done(scan_done), .all_done(all_done),
    .busy(busy), .ovr_flag(ovr_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  // One u_blank pulse; fall is seen at edge k, then `cycles` edges are watched.
  // Iteration i samples the outputs just after edge k+i.
  task automatic pulse_watch(input int cycles, input int extra_at, input int drop_at,
                             input int ovr_at, output int nvalid, output int ndone,
                             output int lat, output int bad);
    logic [DW-1:0] d;
    nvalid = 0; ndone = 0; lat = -1; bad = 0;
    u_blank = 1'b1; tick();
    u_blank = 1'b0; tick();
    for (int i = 1; i <= cycles; i++) begin
      if (i == extra_at) u_blank = 1'b1;
      if (i == extra_at + 1) u_blank = 1'b0;
      if (i == drop_at) enable = 1'b0;
      d = (i == ovr_at) ? '1 : DW'(i * 37 + 5);
      adc_data = d;
      tick();
      if (sample_valid) begin
        if (lat < 0) lat = i;
        if (sample_idx !== LW'(nvalid) || sample_data !== d) bad++;
        nvalid++;
      end
      if (scan_done) ndone++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({sample_valid, scan_done, all_done, busy, ovr_flag} !== 5'b0 ||
        sample_data !== '0 || sample_idx !== '0)
      $display("FAIL reset: outputs v=%b sd=%b ad=%b b=%b o=%b data=%h idx=%0d, required all 0",
               sample_valid, scan_done, all_done, busy, ovr_flag, sample_data, sample_idx);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_single_scan();
    int nv, nd, lat, bad;
    dead_time = 8'd3; record_len = 8'd5; n_scans = 8'd1;
    pulse_watch(11, 0, 0, 0, nv, nd, lat, bad);
    checks++; if (lat !== 4) $display("FAIL single_lat: got %0d required 4", lat); else passed++;
    checks++; if (nv !== 5) $display("FAIL single_nvalid: got %0d required 5", nv); else passed++;
    checks++; if (bad !== 0) $display("FAIL single_idx_data: %0d bad samples required 0", bad); else passed++;
    checks++; if (nd !== 1) $display("FAIL single_scan_done: got %0d required 1", nd); else passed++;
    checks++; if ({all_done, busy} !== 2'b10) $display("FAIL single_done_busy: got %b required 10", {all_done, busy}); else passed++;
    checks++; if (ovr_flag !== 1'b0) $display("FAIL single_ovr: got %b required 0", ovr_flag); else passed++;
    enable = 1'b0; tick();
    checks++; if (all_done !== 1'b0) $display("FAIL single_all_done_clear: got %b required 0", all_done); else passed++;
    enable = 1'b1;
  endtask

  task automatic test_multi_scan();
    int nv, nd, lat, bad;
    dead_time = 8'd0; record_len = 8'd2; n_scans = 8'd3;
    for (int s = 1; s <= 3; s++) begin
      pulse_watch(5, 0, 0, 0, nv, nd, lat, bad);
      checks++;
      if (nv !== 2 || nd !== 1 || lat !== 1 || bad !== 0)
        $display("FAIL multi_scan%0d: nv=%0d nd=%0d lat=%0d bad=%0d required 2 1 1 0", s, nv, nd, lat, bad);
      else passed++;
      checks++;
      if (all_done !== (s == 3))
        $display("FAIL multi_all_done%0d: got %b required %b", s, all_done, s == 3);
      else passed++;
    end
    restart();
  endtask

  task automatic test_no_retrigger();
    int nv, nd, lat, bad;
    dead_time = 8'd0; record_len = 8'd4; n_scans = 8'd0;
    pulse_watch(12, 2, 0, 0, nv, nd, lat, bad);
    checks++;
    if (nv !== 4 || nd !== 1 || bad !== 0)
      $display("FAIL retrigger: nv=%0d nd=%0d bad=%0d required 4 1 0", nv, nd, bad);
    else passed++;
    checks++; if ({all_done, busy} !== 2'b00) $display("FAIL retrigger_state: got %b required 00", {all_done, busy}); else passed++;
    restart();
  endtask

  task automatic test_enable_abort();
    int nv, nd, lat, bad;
    dead_time = 8'd0; record_len = 8'd8; n_scans = 8'd2;
    pulse_watch(11, 0, 0, 0, nv, nd, lat, bad);
    checks++; if (nd !== 1 || all_done !== 1'b0) $display("FAIL abort_first_scan: nd=%0d ad=%b required 1 0", nd, all_done); else passed++;
    // idx 0..2 land on edges k+1..k+3; enable low ahead of edge k+4
    pulse_watch(8, 0, 4, 0, nv, nd, lat, bad);
    checks++;
    if (nv !== 3 || nd !== 0 || busy !== 1'b0 || sample_valid !== 1'b0)
      $display("FAIL abort: nv=%0d nd=%0d busy=%b v=%b required 3 0 0 0", nv, nd, busy, sample_valid);
    else passed++;
    enable = 1'b1; tick();
    // scan_cnt cleared: the next scan must not complete the run
    pulse_watch(11, 0, 0, 0, nv, nd, lat, bad);
    checks++; if (nd !== 1 || all_done !== 1'b0) $display("FAIL abort_cnt_reset1: nd=%0d ad=%b required 1 0", nd, all_done); else passed++;
    pulse_watch(11, 0, 0, 0, nv, nd, lat, bad);
    checks++; if (nd !== 1 || all_done !== 1'b1) $display("FAIL abort_cnt_reset2: nd=%0d ad=%b required 1 1", nd, all_done); else passed++;
    restart();
  endtask

  task automatic test_zero_len();
    int nv, nd, lat, bad, tot_v, tot_d;
    dead_time = 8'd2; record_len = 8'd0; n_scans = 8'd2;
    tot_v = 0; tot_d = 0;
    for (int s = 0; s < 2; s++) begin
      pulse_watch(5, 0, 0, 0, nv, nd, lat, bad);
      tot_v += nv; tot_d += nd;
    end
    checks++;
    if (tot_v !== 0 || tot_d !== 2 || all_done !== 1'b1)
      $display("FAIL zero_len: nv=%0d nd=%0d ad=%b required 0 2 1", tot_v, tot_d, all_done);
    else passed++;
    restart();
  endtask

  task automatic test_ovr();
    int nv, nd, lat, bad;
    logic exp_ovr;
`ifdef ACQ_OVR_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    dead_time = 8'd1; record_len = 8'd4; n_scans = 8'd0;
    pulse_watch(8, 0, 0, 3, nv, nd, lat, bad);
    checks++; if (ovr_flag !== exp_ovr) $display("FAIL ovr_set: got %b required %b", ovr_flag, exp_ovr); else passed++;
    pulse_watch(8, 0, 0, 0, nv, nd, lat, bad);
    checks++; if (ovr_flag !== exp_ovr) $display("FAIL ovr_sticky: got %b required %b", ovr_flag, exp_ovr); else passed++;
    enable = 1'b0; tick();
    checks++; if (ovr_flag !== 1'b0) $display("FAIL ovr_clear: got %b required 0", ovr_flag); else passed++;
    enable = 1'b1; tick();
  endtask

  task automatic test_async_reset();
    dead_time = 8'd0; record_len = 8'd8; n_scans = 8'd0;
    u_blank = 1'b1; tick();
    u_blank = 1'b0; tick(); tick(); tick();
    checks++; if ({sample_valid, busy} !== 2'b11) $display("FAIL async_pre: got %b required 11", {sample_valid, busy}); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sample_valid, busy, scan_done, all_done} !== 4'b0 || sample_idx !== '0)
      $display("FAIL async_reset: v=%b b=%b idx=%0d required 0 0 0", sample_valid, busy, sample_idx);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_multi_scan();
    test_no_retrigger();
    test_enable_abort();
    test_zero_len();
    test_ovr();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
